// File: rtl/lcd_cfg_pkg.sv
// rtl/lcd_cfg_pkg.sv - shared FSM type, frame width and panel register table
package lcd_cfg_pkg;

  localparam int FRAME_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } cfg_state_t;

  // Panel register addresses and values, written in table order
  localparam logic [5:0] CFG_ADDR [16] = '{
    6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
    6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h10, 6'h11, 6'h2A, 6'h3F
  };

  localparam logic [7:0] CFG_DATA [16] = '{
    8'h0F, 8'h5F, 8'h17, 8'h20, 8'h08, 8'hA5, 8'h5A, 8'hC3,
    8'h3C, 8'h81, 8'h7E, 8'hFF, 8'h00, 8'h96, 8'h69, 8'hE1
  };

  // Frame layout: address, write flag (0), reserved (0), data
  function automatic logic [FRAME_W-1:0] cfg_word(input logic [3:0] idx);
    return {CFG_ADDR[idx], 1'b0, 1'b0, CFG_DATA[idx]};
  endfunction

endpackage

// File: rtl/lcd_panel_spi_cfg_shifter.sv
// rtl/lcd_panel_spi_cfg_shifter.sv - 3-wire serial frame shifter (SCEN/SCL/SDA)
module lcd_spi_shifter
  import lcd_cfg_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_abort,
  input  logic               i_load,
  input  logic [FRAME_W-1:0] i_frame,
  output logic               o_scen,
  output logic               o_scl,
  output logic               o_sda,
  output logic               o_frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   r_div;
  logic [3:0]         r_bit;
  logic [FRAME_W-1:0] r_shift;
  logic               r_scen;
  logic               r_scl;
  logic               r_sda;
  logic               w_half_end;

  assign w_half_end   = !r_scen && (r_div == DIV_LAST);
  // Asserted in the last cycle of the frame so the sequencer's gap starts with SCEN high
  assign o_frame_done = w_half_end && r_scl && (r_bit == 4'd15);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_scen  <= 1'b1;
      r_scl   <= 1'b0;
      r_sda   <= 1'b0;
    end else if (i_load) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= i_frame;
      r_scen  <= 1'b0;
      r_scl   <= 1'b0;
      r_sda   <= i_frame[FRAME_W-1];
    end else if (!r_scen) begin
      if (w_half_end) begin
        r_div <= '0;
        if (!r_scl) begin
          r_scl <= 1'b1;
        end else begin
          r_scl <= 1'b0;
          if (r_bit == 4'd15) begin
            r_scen <= 1'b1;
            r_sda  <= 1'b0;
          end else begin
            r_bit   <= r_bit + 4'd1;
            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            r_sda   <= r_shift[FRAME_W-2];
          end
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  assign o_scen = r_scen;
  assign o_scl  = r_scl;
  assign o_sda  = r_sda;

endmodule

// File: rtl/lcd_panel_spi_cfg.sv
// rtl/lcd_panel_spi_cfg.sv - post-reset panel register configurator over 3-wire serial
module lcd_panel_spi_cfg
  import lcd_cfg_pkg::*;
#(
  parameter int          CLK_DIV      = 16,
  parameter logic [19:0] POST_RST_DLY = 20'd100000,
  parameter int          NUM_REGS     = 8
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iGREST_n,
  input  logic iSTART,
  output logic oSCEN,
  output logic oSCL,
  output logic oSDA,
  output logic oBUSY,
  output logic oDONE
);

  localparam int IDX_W = $clog2(NUM_REGS) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [19:0]      GAP_LAST = 20'(2 * CLK_DIV - 1);

  cfg_state_t         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [19:0]        r_dly;
  logic               r_busy;
  logic               r_done;

  logic               w_abort;
  logic               w_dly_hit;
  logic               w_gap_hit;
  logic               w_last;
  logic               w_load;
  logic [IDX_W-1:0]   w_load_idx;
  logic [FRAME_W-1:0] w_frame;
  logic               w_frame_done;
  logic               w_scen;
  logic               w_scl;
  logic               w_sda;

  assign w_abort   = (r_state != ST_IDLE) && !iGREST_n;
  assign w_dly_hit = ({1'b0, r_dly} + 21'd1) >= {1'b0, POST_RST_DLY};
  assign w_gap_hit = (r_dly == GAP_LAST);
  assign w_last    = (r_idx == IDX_LAST);
  assign w_frame   = cfg_word(4'(w_load_idx));

  // The shifter loads on the same edge the FSM enters LOAD, so SCEN falls with LOAD
  always_comb begin
    w_load     = 1'b0;
    w_load_idx = r_idx;
    case (r_state)
      ST_DELAY: begin
        w_load     = w_dly_hit;
        w_load_idx = '0;
      end
      ST_GAP: begin
        w_load     = w_gap_hit && !w_last;
        w_load_idx = r_idx + IDX_W'(1);
      end
      ST_DONE: begin
        w_load     = iSTART;
        w_load_idx = '0;
      end
      default: ;
    endcase
    w_load = w_load && iGREST_n;
  end

  always_ff @(posedge iCLK) begin
    if (iRST || w_abort) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_dly   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iGREST_n) begin
            r_state <= ST_DELAY;
            r_dly   <= '0;
          end
        end
        ST_DELAY: begin
          if (w_dly_hit) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
            r_dly   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_dly <= r_dly + 20'd1;
          end
        end
        ST_LOAD: r_state <= ST_SHIFT;
        ST_SHIFT: begin
          if (w_frame_done) begin
            r_state <= ST_GAP;
            r_dly   <= '0;
          end
        end
        ST_GAP: begin
          if (w_gap_hit) begin
            r_dly <= '0;
            if (w_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
              r_idx   <= w_load_idx;
            end
          end else begin
            r_dly <= r_dly + 20'd1;
          end
        end
        ST_DONE: begin
          if (iSTART) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  lcd_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .i_clk        (iCLK),
    .i_rst        (iRST),
    .i_abort      (w_abort),
    .i_load       (w_load),
    .i_frame      (w_frame),
    .o_scen       (w_scen),
    .o_scl        (w_scl),
    .o_sda        (w_sda),
    .o_frame_done (w_frame_done)
  );

  assign oSCEN = w_scen;
  assign oSCL  = w_scl;
  assign oSDA  = w_sda;
  assign oBUSY = r_busy;
  assign oDONE = r_done;

endmodule
